// File: rtl/cache_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cache_arbiter_pkg
// Purpose : Shared types and constants for the two-port cache-to-memory
//           arbiter. Holds the arbiter FSM state encoding, the grant owner
//           encoding, the default line/address widths and the round-robin
//           tie-break helper.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package cache_arbiter_pkg;

    localparam int LINE_W_DEFAULT = 256;
    localparam int ADDR_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    // Picks the next owner from the two request lines. On a tie the port
    // that did not win last time is chosen, which guarantees alternation
    // when both caches keep requesting. Only meaningful when at least one
    // request is present.
    function automatic grant_t pickWinner(input logic reqA,
                                          input logic reqB,
                                          input grant_t lastGrant);
        grant_t winner;
        if (reqA && reqB) begin
            winner = (lastGrant == GRANT_B) ? GRANT_A : GRANT_B;
        end else if (reqA) begin
            winner = GRANT_A;
        end else begin
            winner = GRANT_B;
        end
        return winner;
    endfunction

endpackage

// File: rtl/cache_arbiter_control.sv
// ---------------------------------------------------------------------------
// arbiter_control
// Purpose : Control half of the cache arbiter. Holds the IDLE/SERVE_A/SERVE_B
//           state machine and the last-grant register and turns them into
//           one-hot grant selects for the datapath muxes in the top level.
// Ports   :
//   clk         - clock, all state on rising edge
//   rst         - synchronous active-high reset
//   reqA_i      - instruction cache request (read)
//   reqB_i      - data cache request (read or write)
//   pmemResp_i  - completion strobe from physical memory
//   grantA_o    - port A currently owns the memory bus
//   grantB_o    - port B currently owns the memory bus
// ---------------------------------------------------------------------------
module arbiter_control
    import cache_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic reqA_i,
    input  logic reqB_i,
    input  logic pmemResp_i,
    output logic grantA_o,
    output logic grantB_o
);

    arb_state_t state_q;
    arb_state_t state_d;
    grant_t     lastGrant_q;
    grant_t     lastGrant_d;
    grant_t     winner;

    // State and last-grant registers. Reset parks the arbiter in IDLE with
    // B recorded as the last owner so that A wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lastGrant_q <= GRANT_B;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    // Next-state logic. A transaction, once granted, runs until memory
    // responds even if the requester drops its request, so nothing ever
    // gets reordered underneath an outstanding memory access.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        winner      = pickWinner(reqA_i, reqB_i, lastGrant_q);
        case (state_q)
            IDLE: begin
                if (reqA_i || reqB_i) begin
                    state_d     = (winner == GRANT_A) ? SERVE_A : SERVE_B;
                    lastGrant_d = winner;
                end
            end
            SERVE_A: begin
                if (pmemResp_i) begin
                    state_d = IDLE;
                end
            end
            SERVE_B: begin
                if (pmemResp_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grants come straight from the registered state, so a request can
    // only reach memory after it has been latched. They are also held low
    // while reset is asserted so an abandoned transaction is silenced in
    // the reset cycle itself, not just from the following one.
    always_comb begin
        grantA_o = (state_q == SERVE_A) && !rst;
        grantB_o = (state_q == SERVE_B) && !rst;
    end

endmodule

// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
// Purpose : Shares one physical memory port between an instruction cache
//           (port A, reads only) and a data cache (port B, reads and
//           writebacks). Round-robin on ties, one transaction at a time.
// Parameters:
//   LINE_W - cache line / memory burst width in bits
//   ADDR_W - physical address width in bits
// Ports   :
//   clk, rst                       - clock, synchronous active-high reset
//   pmem_read_a, pmem_addr_a       - instruction cache fill request
//   pmem_rdata_a, pmem_resp_a      - line data / completion to I-cache
//   pmem_read_b, pmem_write_b      - data cache fill / writeback request
//   pmem_addr_b, pmem_wdata_b      - data cache address / writeback data
//   pmem_rdata_b, pmem_resp_b      - line data / completion to D-cache
//   pmem_read, pmem_write          - command to physical memory
//   pmem_address, pmem_wdata       - address / write data to memory
//   pmem_rdata, pmem_resp          - read data / completion from memory
// ---------------------------------------------------------------------------
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              pmem_read_a,
    input  logic [ADDR_W-1:0] pmem_addr_a,
    output logic [LINE_W-1:0] pmem_rdata_a,
    output logic              pmem_resp_a,

    input  logic              pmem_read_b,
    input  logic              pmem_write_b,
    input  logic [ADDR_W-1:0] pmem_addr_b,
    input  logic [LINE_W-1:0] pmem_wdata_b,
    output logic [LINE_W-1:0] pmem_rdata_b,
    output logic              pmem_resp_b,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    logic grantA;
    logic grantB;
    logic reqB;

    assign reqB = pmem_read_b | pmem_write_b;

    arbiter_control u_control (
        .clk        (clk),
        .rst        (rst),
        .reqA_i     (pmem_read_a),
        .reqB_i     (reqB),
        .pmemResp_i (pmem_resp),
        .grantA_o   (grantA),
        .grantB_o   (grantB)
    );

    // Memory-side steering. Everything defaults to zero so that IDLE and
    // reset present no command. On port B a writeback wins over a fill if
    // the data cache raises both.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        if (grantA) begin
            pmem_read    = pmem_read_a;
            pmem_address = pmem_addr_a;
        end else if (grantB) begin
            pmem_read    = pmem_read_b & ~pmem_write_b;
            pmem_write   = pmem_write_b;
            pmem_address = pmem_addr_b;
            pmem_wdata   = pmem_wdata_b;
        end
    end

    // Response path is zero-latency: the memory strobe goes only to the
    // current owner. Read data fans out to both caches unconditionally;
    // the resp strobe is what tells each cache the data is meant for it.
    always_comb begin
        pmem_resp_a  = grantA & pmem_resp;
        pmem_resp_b  = grantB & pmem_resp;
        pmem_rdata_a = pmem_rdata;
        pmem_rdata_b = pmem_rdata;
    end

endmodule
